// File: rtl/residual_decompress_if.sv
// Handshake bundle for the residual block decompressor: header, packed word
// stream in, reconstructed RGBA pixels out.
interface residual_decompress_if #(
   parameter int NUM_PIXELS = 32
);
   localparam int IDX_W = $clog2(NUM_PIXELS);

   logic             hdr_valid;
   logic             hdr_ready;
   logic [31:0]      hdr_min;
   logic [15:0]      hdr_width;
   logic             hdr_compressable;

   logic             word_valid;
   logic             word_ready;
   logic [31:0]      word_data;

   logic             pix_valid;
   logic             pix_ready;
   logic [31:0]      pix_data;
   logic [IDX_W-1:0] pix_idx;
   logic             pix_last;

   logic             busy;

   modport master (
      output hdr_valid, hdr_min, hdr_width, hdr_compressable,
      output word_valid, word_data, pix_ready,
      input  hdr_ready, word_ready, pix_valid, pix_data, pix_idx, pix_last, busy
   );

   modport slave (
      input  hdr_valid, hdr_min, hdr_width, hdr_compressable,
      input  word_valid, word_data, pix_ready,
      output hdr_ready, word_ready, pix_valid, pix_data, pix_idx, pix_last, busy
   );
endinterface

// File: rtl/residual_decompress.sv
// Residual-packed RGBA block decompressor: latches a block header, pulls the
// LSB-first residual stream and emits NUM_PIXELS reconstructed pixels.
module residual_decompress #(
   parameter int NUM_PIXELS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   residual_decompress_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_PIXELS);
   localparam int CNT_W = $clog2(NUM_PIXELS + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [31:0]      mins_q, mins_d;
   logic [15:0]      wid_q, wid_d;
   logic [5:0]       pix_bits_q, pix_bits_d;
   logic [63:0]      acc_q, acc_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [5:0]       words_q, words_d;
   logic [CNT_W-1:0] ext_q, ext_d;
   logic             pix_valid_q, pix_valid_d;
   logic [31:0]      pix_data_q, pix_data_d;
   logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
   logic             pix_last_q, pix_last_d;

   logic             hdr_ready_c, word_ready_c, busy_c;
   logic             hdr_fire, word_fire, pix_fire, extract;

   function automatic logic [3:0] sat_width(input logic [3:0] w);
      return (w > 4'd8) ? 4'd8 : w;
   endfunction

   function automatic logic [5:0] width_sum(input logic [15:0] wid);
      return {2'b00, wid[3:0]} + {2'b00, wid[7:4]} +
             {2'b00, wid[11:8]} + {2'b00, wid[15:12]};
   endfunction

   // Channels are packed r, g, b, a from bit 0 upward; each adds to its min mod 256.
   function automatic logic [31:0] unpack(input logic [31:0] bits,
                                          input logic [15:0] wid,
                                          input logic [31:0] mins);
      logic [31:0] rem;
      logic [31:0] pix;
      logic [7:0]  mask;
      rem = bits;
      pix = '0;
      for (int c = 0; c < 4; c++) begin
         mask           = 8'((9'd1 << wid[4*c +: 4]) - 9'd1);
         pix[8*c +: 8]  = mins[8*c +: 8] + (rem[7:0] & mask);
         rem            = rem >> wid[4*c +: 4];
      end
      return pix;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.hdr_valid) state_d = RUN;
         RUN:     if (pix_fire && pix_last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hdr_ready_c  = (state_q == IDLE);
      busy_c       = (state_q != IDLE);
      word_ready_c = (state_q == RUN) && (cnt_q < {1'b0, pix_bits_q}) &&
                     (words_q < pix_bits_q);
   end

   assign bus.hdr_ready  = hdr_ready_c;
   assign bus.busy       = busy_c;
   assign bus.word_ready = word_ready_c;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_data   = pix_data_q;
   assign bus.pix_idx    = pix_idx_q;
   assign bus.pix_last   = pix_last_q;

   assign hdr_fire  = bus.hdr_valid && hdr_ready_c;
   assign word_fire = bus.word_valid && word_ready_c;
   assign pix_fire  = pix_valid_q && bus.pix_ready;
   // The extraction counter stops zero-width blocks from emitting forever.
   assign extract   = (state_q == RUN) && (cnt_q >= {1'b0, pix_bits_q}) &&
                      (ext_q < CNT_W'(NUM_PIXELS)) && (!pix_valid_q || bus.pix_ready);

   always_comb begin
      mins_d      = mins_q;
      wid_d       = wid_q;
      pix_bits_d  = pix_bits_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      words_d     = words_q;
      ext_d       = ext_q;
      pix_valid_d = pix_valid_q;
      pix_data_d  = pix_data_q;
      pix_idx_d   = pix_idx_q;
      pix_last_d  = pix_last_q;

      if (hdr_fire) begin
         if (bus.hdr_compressable) begin
            mins_d = bus.hdr_min;
            wid_d  = {sat_width(bus.hdr_width[15:12]), sat_width(bus.hdr_width[11:8]),
                      sat_width(bus.hdr_width[7:4]),   sat_width(bus.hdr_width[3:0])};
         end else begin
            mins_d = '0;
            wid_d  = 16'h8888;
         end
         pix_bits_d = width_sum(wid_d);
         acc_d      = '0;
         cnt_d      = '0;
         words_d    = '0;
         ext_d      = '0;
      end else if (word_fire) begin
         acc_d   = acc_q | ({32'd0, bus.word_data} << cnt_q);
         cnt_d   = cnt_q + 7'd32;
         words_d = words_q + 6'd1;
      end else if (extract) begin
         acc_d = acc_q >> pix_bits_q;
         cnt_d = cnt_q - {1'b0, pix_bits_q};
         ext_d = ext_q + 1'b1;
      end

      if (extract) begin
         pix_valid_d = 1'b1;
         pix_data_d  = unpack(acc_q[31:0], wid_q, mins_q);
         pix_idx_d   = IDX_W'(ext_q);
         pix_last_d  = (ext_q == CNT_W'(NUM_PIXELS - 1));
      end else if (pix_fire) begin
         pix_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mins_q      <= '0;
         wid_q       <= '0;
         pix_bits_q  <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         words_q     <= '0;
         ext_q       <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_idx_q   <= '0;
         pix_last_q  <= 1'b0;
      end else begin
         mins_q      <= mins_d;
         wid_q       <= wid_d;
         pix_bits_q  <= pix_bits_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         words_q     <= words_d;
         ext_q       <= ext_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_idx_q   <= pix_idx_d;
         pix_last_q  <= pix_last_d;
      end
   end
endmodule

// File: tb/tb_residual_decompress.sv
// Directed bench for residual_decompress: table of constant-word blocks plus
// raw, randomised-stall and mid-block reset sequences.
module tb_residual_decompress;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0]  words [0:31];
   logic [31:0]  expq  [0:31];
   logic [511:0] bs;

   residual_decompress_if #(.NUM_PIXELS(32)) bus ();
   residual_decompress #(.NUM_PIXELS(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mn;
      logic [15:0] wd;
      logic        cm;
      logic [31:0] word;
      int          nw;
      logic [31:0] px;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".hdr_ready"},  {31'd0, bus.hdr_ready},  32'd1);
      chk({tag, ".word_ready"}, {31'd0, bus.word_ready}, 32'd0);
      chk({tag, ".pix_valid"},  {31'd0, bus.pix_valid},  32'd0);
      chk({tag, ".pix_data"},   bus.pix_data,            32'd0);
      chk({tag, ".pix_idx"},    {27'd0, bus.pix_idx},    32'd0);
      chk({tag, ".pix_last"},   {31'd0, bus.pix_last},   32'd0);
      chk({tag, ".busy"},       {31'd0, bus.busy},       32'd0);
   endtask

   // Inputs change on the falling edge; handshakes are decided there for the next rising edge.
   task automatic run_block(input string tag, input logic [31:0] mn, input logic [15:0] wd,
                            input logic cm, input int nw, input bit stall, input int lat,
                            input int stop_after);
      int          wi, pi, cyc, last_cyc, wr_hi;
      bit          was_stalled;
      logic [31:0] held;
      logic [4:0]  held_idx;
      bus.word_valid = 1'b0;
      bus.pix_ready  = 1'b1;
      @(negedge clk);
      chk({tag, ".hdr_ready"}, {31'd0, bus.hdr_ready}, 32'd1);
      bus.hdr_valid        = 1'b1;
      bus.hdr_min          = mn;
      bus.hdr_width        = wd;
      bus.hdr_compressable = cm;
      @(negedge clk);
      bus.hdr_valid = 1'b0;
      chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
      wi = 0; pi = 0; cyc = 0; last_cyc = -1; wr_hi = 0;
      was_stalled = 1'b0; held = '0; held_idx = '0;
      while (pi < stop_after && cyc < 3000) begin
         bus.word_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.word_data  = (wi < 32) ? words[wi] : 32'hDEADBEEF;
         bus.pix_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.word_ready) wr_hi++;
         if (was_stalled) begin
            chk({tag, ".stall_valid"}, {31'd0, bus.pix_valid}, 32'd1);
            chk({tag, ".stall_data"},  bus.pix_data, held);
            chk({tag, ".stall_idx"},   {27'd0, bus.pix_idx}, {27'd0, held_idx});
         end
         if (bus.word_valid && bus.word_ready) wi++;
         if (bus.pix_valid && bus.pix_ready) begin
            chk($sformatf("%s.data[%0d]", tag, pi), bus.pix_data, expq[pi]);
            chk($sformatf("%s.idx[%0d]", tag, pi), {27'd0, bus.pix_idx}, 32'(pi));
            chk($sformatf("%s.last[%0d]", tag, pi), {31'd0, bus.pix_last},
                (pi == 31) ? 32'd1 : 32'd0);
            pi++;
            if (pi == 32) last_cyc = cyc;
         end
         was_stalled = bus.pix_valid && !bus.pix_ready;
         held        = bus.pix_data;
         held_idx    = bus.pix_idx;
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".pixels"}, 32'(pi), 32'(stop_after));
      if (stop_after == 32) begin
         chk({tag, ".words"}, 32'(wi), 32'(nw));
         chk({tag, ".hdr_ready_after"}, {31'd0, bus.hdr_ready}, 32'd1);
         chk({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
         if (lat >= 0) chk({tag, ".latency"}, 32'(last_cyc), 32'(lat));
         if (nw == 0) chk({tag, ".word_ready_cycles"}, 32'(wr_hi), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] rr, rg, rb, ra;
      bus.hdr_valid = 1'b0; bus.hdr_min = '0; bus.hdr_width = '0; bus.hdr_compressable = 1'b0;
      bus.word_valid = 1'b0; bus.word_data = '0; bus.pix_ready = 1'b0;

      // mn, wd, cm, word, words consumed, pixel, cycles to last pixel
      vecs[0] = '{32'h281E140A, 16'h2222, 1'b1, 32'hFFFFFFFF, 8,  32'h2B21170D, 40};
      vecs[1] = '{32'h08070605, 16'h0000, 1'b1, 32'hFFFFFFFF, 0,  32'h08070605, 32};
      vecs[2] = '{32'h332211F0, 16'h000F, 1'b1, 32'h20202020, 8,  32'h33221110, 40};
      vecs[3] = '{32'h01FF0180, 16'h8888, 1'b1, 32'h81028001, 32, 32'h82018181, 64};
      vecs[4] = '{32'hFFFFFFFF, 16'h1234, 1'b0, 32'hA5C30F96, 32, 32'hA5C30F96, 64};
      vecs[5] = '{32'h40302010, 16'h0044, 1'b1, 32'h5A5A5A5A, 8,  32'h4030251A, 40};

      #1 rst = 1'b1;
      #1 chk_reset("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 32; k++) begin
            words[k] = vecs[i].word;
            expq[k]  = vecs[i].px;
         end
         run_block($sformatf("vec%0d", i), vecs[i].mn, vecs[i].wd, vecs[i].cm,
                   vecs[i].nw, 1'b0, vecs[i].lat, 32);
      end

      for (int k = 0; k < 32; k++) begin
         words[k] = 32'(k);
         expq[k]  = 32'(k);
      end
      run_block("raw_inc", 32'h12345678, 16'h3210, 1'b0, 32, 1'b0, 64, 32);

      // Widths 3/5/7/1 give 16-bit pixels, two per word.
      bs = '0;
      for (int k = 0; k < 32; k++) begin
         rr = 8'($urandom_range(0, 7));
         rg = 8'($urandom_range(0, 31));
         rb = 8'($urandom_range(0, 127));
         ra = 8'($urandom_range(0, 1));
         bs[16*k +: 16] = {ra[0], rb[6:0], rg[4:0], rr[2:0]};
         expq[k] = {8'h7F + ra, 8'h80 + rb, 8'h10 + rg, 8'hFE + rr};
      end
      for (int k = 0; k < 32; k++) words[k] = (k < 16) ? bs[32*k +: 32] : 32'hDEADBEEF;
      run_block("rand_stall", 32'h7F8010FE, 16'h1753, 1'b1, 16, 1'b1, -1, 32);

      for (int k = 0; k < 32; k++) begin
         words[k] = 32'hC0DE0000 | 32'(k);
         expq[k]  = 32'hC0DE0000 | 32'(k);
      end
      run_block("rst_pre", 32'h0, 16'h0, 1'b0, 32, 1'b0, -1, 11);
      #3 rst = 1'b1;
      #1 chk_reset("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      bus.word_valid = 1'b1;
      bus.word_data  = 32'hBAD0BAD0;
      @(negedge clk);
      chk("post_rst.word_ready", {31'd0, bus.word_ready}, 32'd0);
      chk("post_rst.hdr_ready",  {31'd0, bus.hdr_ready},  32'd1);
      chk("post_rst.pix_valid",  {31'd0, bus.pix_valid},  32'd0);
      for (int k = 0; k < 32; k++) begin
         words[k] = ~(32'(k) * 32'h01010101);
         expq[k]  = ~(32'(k) * 32'h01010101);
      end
      run_block("post_rst", 32'h0, 16'h0, 1'b0, 32, 1'b0, 64, 32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
